// File: rtl/cdma_dma_rd_req_arb.sv
// Round-robin arbiter sharing the CDMA DMA read-request pipe between weight, feature and image
// requesters, with per-requester outstanding-read credit limiting and a registered output stage.
module cdma_dma_rd_req_arb #(
  parameter int PD_WIDTH = 79,
  parameter int MAX_OS   = 8,
  parameter int CNT_W    = 4
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                arb_en,
  input  logic                req0_vld,
  input  logic [PD_WIDTH-1:0] req0_pd,
  output logic                req0_rdy,
  input  logic                req1_vld,
  input  logic [PD_WIDTH-1:0] req1_pd,
  output logic                req1_rdy,
  input  logic                req2_vld,
  input  logic [PD_WIDTH-1:0] req2_pd,
  output logic                req2_rdy,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [PD_WIDTH-1:0] out_pd,
  output logic [1:0]          out_id,
  input  logic                rtn_vld,
  input  logic [1:0]          rtn_id,
  output logic                arb_idle
);

  logic [2:0]          vld;
  logic [2:0]          elig;
  logic [2:0]          gnt;
  logic [2:0]          cnt_inc;
  logic [2:0]          cnt_dec;
  logic [1:0]          gnt_idx;
  logic [1:0]          last_grant;
  logic                acc;
  logic [PD_WIDTH-1:0] pd  [3];
  logic [CNT_W-1:0]    cnt [3];

  assign vld   = {req2_vld, req1_vld, req0_vld};
  assign pd[0] = req0_pd;
  assign pd[1] = req1_pd;
  assign pd[2] = req2_pd;
  assign acc   = !out_vld || out_rdy;

  always_comb begin
    elig    = '0;
    cnt_dec = '0;
    for (int i = 0; i < 3; i++) begin
      elig[i]    = vld[i] && (cnt[i] < CNT_W'(MAX_OS)) && arb_en;
      // A return against an empty counter is dropped rather than wrapping.
      cnt_dec[i] = rtn_vld && (rtn_id == 2'(i)) && (cnt[i] != '0);
    end
  end

  // Search order starts just after the last granted requester.
  always_comb begin
    gnt = '0;
    if (acc && !nvdla_core_rst) begin
      case (last_grant)
        2'd0: begin
          if (elig[1])      gnt = 3'b010;
          else if (elig[2]) gnt = 3'b100;
          else if (elig[0]) gnt = 3'b001;
        end
        2'd1: begin
          if (elig[2])      gnt = 3'b100;
          else if (elig[0]) gnt = 3'b001;
          else if (elig[1]) gnt = 3'b010;
        end
        default: begin
          if (elig[0])      gnt = 3'b001;
          else if (elig[1]) gnt = 3'b010;
          else if (elig[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    gnt_idx = 2'd0;
    if (gnt[1]) gnt_idx = 2'd1;
    if (gnt[2]) gnt_idx = 2'd2;
  end

  assign cnt_inc  = gnt;
  assign req0_rdy = gnt[0];
  assign req1_rdy = gnt[1];
  assign req2_rdy = gnt[2];

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      out_vld    <= 1'b0;
      out_pd     <= '0;
      out_id     <= 2'd0;
      last_grant <= 2'd2;
    end else if (acc) begin
      if (gnt != '0) begin
        out_vld    <= 1'b1;
        out_pd     <= pd[gnt_idx];
        out_id     <= gnt_idx;
        last_grant <= gnt_idx;
      end else begin
        out_vld <= 1'b0;
      end
    end
  end

  // Grant and return on the same counter cancel out.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (cnt_dec[i] && !cnt_inc[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign arb_idle = !out_vld && (cnt[0] == '0) && (cnt[1] == '0) && (cnt[2] == '0);

endmodule

// File: tb/tb_cdma_dma_rd_req_arb.sv
// Randomized bench for cdma_dma_rd_req_arb against a transaction-level model of the
// round-robin, credit-limited request arbiter.
module tb_cdma_dma_rd_req_arb;
  localparam int PD_WIDTH = 79;
  localparam int MAX_OS   = 8;

  logic                nvdla_core_clk = 1'b0;
  logic                nvdla_core_rst;
  logic                arb_en;
  logic                req0_vld, req1_vld, req2_vld;
  logic [PD_WIDTH-1:0] req0_pd, req1_pd, req2_pd;
  logic                req0_rdy, req1_rdy, req2_rdy;
  logic                out_vld, out_rdy;
  logic [PD_WIDTH-1:0] out_pd;
  logic [1:0]          out_id;
  logic                rtn_vld;
  logic [1:0]          rtn_id;
  logic                arb_idle;

  cdma_dma_rd_req_arb #(.PD_WIDTH(PD_WIDTH), .MAX_OS(MAX_OS), .CNT_W(4)) dut (
    .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rst(nvdla_core_rst), .arb_en(arb_en),
    .req0_vld(req0_vld), .req0_pd(req0_pd), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_pd(req1_pd), .req1_rdy(req1_rdy),
    .req2_vld(req2_vld), .req2_pd(req2_pd), .req2_rdy(req2_rdy),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pd(out_pd), .out_id(out_id),
    .rtn_vld(rtn_vld), .rtn_id(rtn_id), .arb_idle(arb_idle)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model: what has been issued and how many reads each requester has in flight
  logic                m_vld;
  logic [PD_WIDTH-1:0] m_pd;
  int                  m_id;
  int                  m_last;
  int                  m_cnt [3];
  int                  n_grant;

  task automatic chk(input string tag, input logic [PD_WIDTH-1:0] got, input logic [PD_WIDTH-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_pd   = '0;
    m_id   = 0;
    m_last = 2;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [PD_WIDTH-1:0] rnd_pd();
    return PD_WIDTH'({$urandom, $urandom, $urandom});
  endfunction

  // one clock: drive, check combinational and registered outputs, advance the model
  task automatic cycle(input logic [2:0] v, input logic ordy, input logic rv, input logic [1:0] rid,
                       input logic en);
    logic [PD_WIDTH-1:0] p [3];
    int  g, idx;
    logic m_acc, m_idle;
    for (int i = 0; i < 3; i++) p[i] = rnd_pd();
    req0_vld = v[0]; req1_vld = v[1]; req2_vld = v[2];
    req0_pd = p[0];  req1_pd = p[1];  req2_pd = p[2];
    out_rdy = ordy;  rtn_vld = rv;    rtn_id = rid;  arb_en = en;
    #1;
    m_acc = !m_vld || ordy;
    g = -1;
    if (m_acc)
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (g < 0 && v[idx] && en && m_cnt[idx] < MAX_OS) g = idx;
      end
    m_idle = !m_vld && m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0;
    chk("req0_rdy", PD_WIDTH'(req0_rdy), PD_WIDTH'(g == 0));
    chk("req1_rdy", PD_WIDTH'(req1_rdy), PD_WIDTH'(g == 1));
    chk("req2_rdy", PD_WIDTH'(req2_rdy), PD_WIDTH'(g == 2));
    chk("out_vld", PD_WIDTH'(out_vld), PD_WIDTH'(m_vld));
    if (m_vld) begin
      chk("out_pd", out_pd, m_pd);
      chk("out_id", PD_WIDTH'(out_id), PD_WIDTH'(m_id));
    end
    chk("arb_idle", PD_WIDTH'(arb_idle), PD_WIDTH'(m_idle));
    @(posedge nvdla_core_clk);
    if (m_acc) begin
      if (g >= 0) begin
        m_vld = 1'b1; m_pd = p[g]; m_id = g; m_last = g; n_grant++;
      end else begin
        m_vld = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++)
      m_cnt[i] = m_cnt[i] + ((g == i) ? 1 : 0) - ((rv && int'(rid) == i && m_cnt[i] > 0) ? 1 : 0);
    #1;
  endtask

  task automatic rand_phase(input int n, input int rdy_pct, input int rtn_pct);
    for (int c = 0; c < n; c++)
      cycle(3'($urandom_range(0, 7)), $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 99) < rtn_pct, 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) != 0);
  endtask

  task automatic pulse_reset();
    #1;
    nvdla_core_rst = 1'b1;
    #1;
    chk("rst_out_vld", PD_WIDTH'(out_vld), '0);
    chk("rst_out_pd", out_pd, '0);
    chk("rst_out_id", PD_WIDTH'(out_id), '0);
    chk("rst_idle", PD_WIDTH'(arb_idle), PD_WIDTH'(1));
    chk("rst_rdy", PD_WIDTH'({req2_rdy, req1_rdy, req0_rdy}), '0);
    model_reset();
    req0_vld = 1'b0; req1_vld = 1'b0; req2_vld = 1'b0; rtn_vld = 1'b0;
    @(negedge nvdla_core_clk);
    nvdla_core_rst = 1'b0;
    @(posedge nvdla_core_clk);
    #1;
  endtask

  initial begin
    n_grant = 0;
    model_reset();
    nvdla_core_rst = 1'b1;
    arb_en = 1'b1; out_rdy = 1'b1; rtn_vld = 1'b0; rtn_id = 2'd0;
    req0_vld = 1'b1; req1_vld = 1'b1; req2_vld = 1'b1;
    req0_pd = rnd_pd(); req1_pd = rnd_pd(); req2_pd = rnd_pd();
    #3;
    chk("init_out_vld", PD_WIDTH'(out_vld), '0);
    chk("init_out_pd", out_pd, '0);
    chk("init_idle", PD_WIDTH'(arb_idle), PD_WIDTH'(1));
    chk("init_rdy", PD_WIDTH'({req2_rdy, req1_rdy, req0_rdy}), '0);
    req0_vld = 1'b0; req1_vld = 1'b0; req2_vld = 1'b0;
    #5;
    nvdla_core_rst = 1'b0;
    @(posedge nvdla_core_clk);
    #1;

    // saturate all three credit pools: 24 grants, then everything stalls
    for (int c = 0; c < 30; c++) cycle(3'b111, 1'b1, 1'b0, 2'd0, 1'b1);
    chk("sat_grants", PD_WIDTH'(n_grant), PD_WIDTH'(3 * MAX_OS));
    // at the limit a return unblocks only its own requester, one cycle later
    cycle(3'b111, 1'b1, 1'b1, 2'd2, 1'b1);
    cycle(3'b111, 1'b1, 1'b0, 2'd0, 1'b1);
    cycle(3'b111, 1'b1, 1'b0, 2'd0, 1'b1);

    // drain credits, returns with id 3 and at zero mixed in
    for (int c = 0; c < 40; c++) cycle(3'b000, 1'b1, 1'b1, 2'(c % 4), 1'b1);

    // single requester streaming, then backpressure
    for (int c = 0; c < 6; c++) cycle(3'b010, 1'b1, 1'b1, 2'd1, 1'b1);
    for (int c = 0; c < 5; c++) cycle(3'b111, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int c = 0; c < 4; c++) cycle(3'b111, 1'b1, 1'b1, 2'(c % 3), 1'b1);
    // arb_en low with an output pending
    for (int c = 0; c < 4; c++) cycle(3'b111, c == 2, 1'b1, 2'(c % 3), 1'b0);

    rand_phase(400, 70, 50);
    rand_phase(200, 20, 30);

    // reset while an output is pending and credits are held
    for (int c = 0; c < 5; c++) cycle(3'b010, 1'b0, 1'b0, 2'd0, 1'b1);
    pulse_reset();
    cycle(3'b111, 1'b1, 1'b0, 2'd0, 1'b1);
    cycle(3'b111, 1'b1, 1'b0, 2'd0, 1'b1);
    rand_phase(300, 60, 40);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
